uart_tx_slave: RTL

UART_TX_SLAVE -- requirements
Module: uart_tx_slave

---
 rtl/uart_tx_slave_pkg.sv | 35 +++
 rtl/uart_tx_core.sv | 98 +++++++++
 rtl/uart_tx_slave.sv | 109 ++++++++++
 3 files changed

// File: rtl/uart_tx_slave_pkg.sv
// rtl/uart_tx_slave_pkg.sv - UART0 window, register map, STATUS bits and TX FSM encoding
`ifndef XLEN
`define XLEN 32
`endif

package uart_tx_slave_pkg;

  localparam logic [31:0] UART0_BASE = 32'h1000_0000;
  localparam logic [31:0] UART0_SIZE = 32'h0000_1000;

  // Register select is offset[3:2]; higher offset bits alias into these four slots.
  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUD_DIV = 2'd2;
  localparam logic [1:0] REG_RESERVED = 2'd3;

  localparam int STAT_TX_BUSY   = 0;
  localparam int STAT_HOLD_FULL = 1;
  localparam int STAT_OVERRUN   = 2;

  localparam int BAUD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Reload value for the bit counter; a divisor of 0 behaves like 1.
  function automatic logic [BAUD_W-1:0] bit_len_m1(input logic [BAUD_W-1:0] div);
    return (div == '0) ? '0 : div - 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 serialiser: baud counter plus IDLE/START/DATA/STOP shifter FSM
module uart_tx_core
  import uart_tx_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] i_baud_div,
  input  logic              i_valid,
  input  logic [7:0]        i_byte,
  output logic              o_take,
  output logic              o_busy,
  output logic              o_tx
);

  tx_state_e         r_state;
  logic [BAUD_W-1:0] r_cnt;
  logic [2:0]        r_idx;
  logic [7:0]        r_shift;
  logic              r_tx;

  logic              w_bit_end;
  logic [BAUD_W-1:0] w_len_m1;

  assign w_bit_end = (r_cnt == '0);
  assign w_len_m1  = bit_len_m1(i_baud_div);

  // A byte is consumed when leaving IDLE or when a stop bit chains straight into a new start.
  assign o_take = i_valid & ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_end));
  assign o_busy = (r_state != ST_IDLE);
  assign o_tx   = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_state <= ST_START;
            r_shift <= i_byte;
            r_cnt   <= w_len_m1;
            r_tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_cnt   <= w_len_m1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_idx <= r_idx + 3'd1;
            r_cnt <= w_len_m1;
            if (r_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (i_valid) begin
              r_state <= ST_START;
              r_shift <= i_byte;
              r_cnt   <= w_len_m1;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_slave.sv
// rtl/uart_tx_slave.sv - UART0 transmit slave: bus decode, TXDATA/STATUS/BAUD_DIV registers
`ifndef XLEN
`define XLEN 32
`endif

module uart_tx_slave
  import uart_tx_slave_pkg::*;
#(
  parameter int DEFAULT_DIV = 868,
  parameter int XLEN        = `XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_addr_detect,
  input  logic [XLEN-1:0] uart_addr,
  input  logic            mem_wr_en,
  input  logic            mem_rd_en,
  input  logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] uart_rdata,
  output logic            uart_rvalid,
  output logic            uart_tx
);

  logic [BAUD_W-1:0] r_baud_div;
  logic [7:0]        r_hold;
  logic              r_hold_full;
  logic              r_overrun;
  logic              r_rvalid;
  logic [XLEN-1:0]   r_rdata;

  logic [1:0]        w_sel;
  logic              w_wr;
  logic              w_rd;
  logic              w_tx_wr;
  logic              w_take;
  logic              w_busy;
  logic              w_hold_free;
  logic [XLEN-1:0]   w_rmux;
  logic              w_unused_bits;

  assign w_sel       = uart_addr[3:2];
  assign w_wr        = uart_addr_detect & mem_wr_en;
  assign w_rd        = uart_addr_detect & mem_rd_en;
  assign w_tx_wr     = w_wr & (w_sel == REG_TXDATA);
  // The holding register counts as free in the very cycle the core takes its byte.
  assign w_hold_free = ~r_hold_full | w_take;

  assign w_unused_bits = ^{uart_addr[XLEN-1:4], uart_addr[1:0], mem_wdata[XLEN-1:BAUD_W]};

  uart_tx_core u_core (
    .clk        (clk),
    .rst        (rst),
    .i_baud_div (r_baud_div),
    .i_valid    (r_hold_full),
    .i_byte     (r_hold),
    .o_take     (w_take),
    .o_busy     (w_busy),
    .o_tx       (uart_tx)
  );

  always_comb begin
    w_rmux = '0;
    case (w_sel)
      REG_STATUS: begin
        w_rmux[STAT_TX_BUSY]   = w_busy;
        w_rmux[STAT_HOLD_FULL] = r_hold_full;
        w_rmux[STAT_OVERRUN]   = r_overrun;
      end
      REG_BAUD_DIV: w_rmux[BAUD_W-1:0] = r_baud_div;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_div  <= BAUD_W'(DEFAULT_DIV);
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_overrun   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (w_wr && (w_sel == REG_BAUD_DIV)) begin
        r_baud_div <= mem_wdata[BAUD_W-1:0];
      end

      if (w_tx_wr && w_hold_free) begin
        r_hold      <= mem_wdata[7:0];
        r_hold_full <= 1'b1;
      end else if (w_take) begin
        r_hold_full <= 1'b0;
      end

      // A fresh overrun in the same cycle as a STATUS read wins over the clear.
      if (w_tx_wr && !w_hold_free) begin
        r_overrun <= 1'b1;
      end else if (w_rd && (w_sel == REG_STATUS)) begin
        r_overrun <= 1'b0;
      end

      r_rvalid <= w_rd;
      r_rdata  <= w_rd ? w_rmux : '0;
    end
  end

  assign uart_rvalid = r_rvalid;
  assign uart_rdata  = r_rdata;

endmodule
